// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - flit width and field offsets shared by openNocTop, PE models and injectors
package noc_pkg;

    // Flit layout, LSB first: payload, then y, then x.
    function automatic int flit_width(input int x_size, input int y_size, input int data_width);
        return x_size + y_size + data_width;
    endfunction

    function automatic int payload_lsb();
        return 0;
    endfunction

    function automatic int y_lsb(input int data_width);
        return data_width;
    endfunction

    function automatic int x_lsb(input int y_size, input int data_width);
        return data_width + y_size;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, first request at or above ptr
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);

    logic found;
    int   cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr_i) + k) % N;
            if (en_i && !found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/pe_inject_arbiter.sv
// rtl/pe_inject_arbiter.sv - round-robin PE injection arbiter; INJ_RATE_LIMIT_EN adds min inject gap
module pe_inject_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int X_SIZE     = 1,
    parameter int Y_SIZE     = 1,
    parameter int DATA_WIDTH = 256,
    parameter int RATE       = 1,
    localparam int TW        = flit_width(X_SIZE, Y_SIZE, DATA_WIDTH),
    localparam int IW        = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*TW-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  noc_valid,
    output logic [TW-1:0]         noc_data,
    input  logic                  noc_ready,
    output logic [IW-1:0]         grant_id,
    output logic                  idle
);

    if (NUM_REQ < 2 || RATE < 1) begin : g_bad_cfg
        $error("pe_inject_arbiter: NUM_REQ must be >= 2 and RATE >= 1");
    end

    logic               noc_valid_q, noc_valid_d;
    logic [TW-1:0]      noc_data_q, noc_data_d;
    logic [IW-1:0]      grant_id_q, grant_id_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic               gap_ok;
    logic               slot_free;
    logic               can_load;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      winner;

    assign slot_free = !noc_valid_q || noc_ready;
    assign can_load  = enable && slot_free && gap_ok && (|req_valid);

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .en_i    (can_load),
        .grant_o (grant),
        .idx_o   (winner)
    );

    always_comb begin
        noc_valid_d = noc_valid_q;
        noc_data_d  = noc_data_q;
        grant_id_d  = grant_id_q;
        ptr_d       = ptr_q;
        if (can_load) begin
            noc_valid_d = 1'b1;
            noc_data_d  = req_data[winner*TW +: TW];
            grant_id_d  = winner;
            ptr_d       = (winner == IW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
        end else if (noc_valid_q && noc_ready) begin
            noc_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            noc_valid_q <= 1'b0;
            noc_data_q  <= '0;
            grant_id_q  <= '0;
            ptr_q       <= '0;
        end else begin
            noc_valid_q <= noc_valid_d;
            noc_data_q  <= noc_data_d;
            grant_id_q  <= grant_id_d;
            ptr_q       <= ptr_d;
        end
    end

`ifdef INJ_RATE_LIMIT_EN
    localparam int CW = $clog2(RATE+1);
    logic [CW-1:0] gap_q, gap_d;

    // Loaded with RATE-1 so the next load is exactly RATE cycles after this one.
    always_comb begin
        gap_d = gap_q;
        if (can_load)
            gap_d = CW'(RATE-1);
        else if (gap_q != '0)
            gap_d = gap_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) gap_q <= '0;
        else     gap_q <= gap_d;
    end

    assign gap_ok = (gap_q == '0);
`else
    assign gap_ok = 1'b1;
`endif

    assign req_ready = grant;
    assign noc_valid = noc_valid_q;
    assign noc_data  = noc_data_q;
    assign grant_id  = grant_id_q;
    assign idle      = !noc_valid_q && !(|req_valid);

endmodule

// File: tb/tb_pe_inject_arbiter.sv
// tb/tb_pe_inject_arbiter.sv - randomized bench for pe_inject_arbiter against a flit-level model
module tb_pe_inject_arbiter;

    localparam int N    = 4;
    localparam int XS   = 1;
    localparam int YS   = 1;
    localparam int DW   = 16;
    localparam int TW   = XS + YS + DW;
    localparam int RATE = 4;
`ifdef INJ_RATE_LIMIT_EN
    localparam int GAP  = RATE;
`else
    localparam int GAP  = 1;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [N-1:0]    req_valid;
    logic [N*TW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            noc_valid;
    logic [TW-1:0]   noc_data;
    logic            noc_ready;
    logic [1:0]      grant_id;
    logic            idle;

    pe_inject_arbiter #(
        .NUM_REQ(N), .X_SIZE(XS), .Y_SIZE(YS), .DATA_WIDTH(DW), .RATE(RATE)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .noc_valid(noc_valid), .noc_data(noc_data), .noc_ready(noc_ready),
        .grant_id(grant_id), .idle(idle)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference: contents of the single-flit output slot, the round-robin
    // start position and the number of cycles since the last accepted flit.
    logic          m_valid;
    logic [TW-1:0] m_data;
    int            m_id;
    int            m_ptr;
    int            since;
    int            cyc;
    int            xfer_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_ptr   = 0;
        since   = GAP;
    endtask

    task automatic step(input logic en, input logic [N-1:0] v, input logic rdy);
        int w;
        logic [N-1:0] exp_rr;
        @(negedge clk);
        enable    = en;
        req_valid = v;
        noc_ready = rdy;
        for (int i = 0; i < N; i++) req_data[i*TW +: TW] = TW'($urandom);
        #1;
        check("noc_valid", 32'(noc_valid), 32'(m_valid));
        check("noc_data", 32'(noc_data), 32'(m_data));
        check("grant_id", 32'(grant_id), 32'(m_id));
        check("idle", 32'(idle), 32'(!m_valid && v == '0));
        w = -1;
        if (en && (!m_valid || rdy) && since >= GAP) begin
            for (int k = 0; k < N; k++)
                if (w < 0 && v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
        exp_rr = '0;
        if (w >= 0) exp_rr[w] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rr));
        if (w >= 0) begin
            m_valid = 1'b1;
            m_data  = req_data[w*TW +: TW];
            m_id    = w;
            m_ptr   = (w + 1) % N;
            since   = 1;
            xfer_cyc.push_back(cyc);
        end else begin
            if (m_valid && rdy) m_valid = 1'b0;
            if (since < GAP) since++;
        end
        cyc++;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; req_valid = '0; req_data = '0; noc_ready = 1'b0;
        cyc = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        repeat (3) step(1'b1, 4'b0000, 1'b1);

        // Saturated traffic: order 0,1,2,3,0 and injections GAP cycles apart.
        xfer_cyc.delete();
        repeat (13) step(1'b1, 4'b1111, 1'b1);
        for (int i = 1; i < xfer_cyc.size(); i++)
            check("xfer_spacing", 32'(xfer_cyc[i] - xfer_cyc[i-1]), 32'(GAP));
        check("xfer_count", 32'(xfer_cyc.size()), 32'((12 / GAP) + 1));
        repeat (GAP + 2) step(1'b1, 4'b0000, 1'b1);

        // Requester 2 alone under 5 cycles of backpressure.
        step(1'b1, 4'b0100, 1'b1);
        repeat (5) step(1'b1, 4'b0100, 1'b0);
        repeat (GAP + 2) step(1'b1, 4'b0100, 1'b1);
        repeat (GAP + 1) step(1'b1, 4'b0000, 1'b1);

        // Enable dropped with a flit buffered, then restored.
        step(1'b1, 4'b1111, 1'b0);
        repeat (2) step(1'b0, 4'b1111, 1'b0);
        repeat (4) step(1'b0, 4'b1111, 1'b1);
        repeat (GAP + 3) step(1'b1, 4'b1111, 1'b1);

        // Asynchronous reset while the slot is stalled.
        repeat (GAP) step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b1000, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        #2 rst = 1'b1;
        #1 check("rst_async_valid", 32'(noc_valid), 32'(0));
        check("rst_async_grant", 32'(grant_id), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1'b1, 4'b1010, 1'b1);
        step(1'b1, 4'b0000, 1'b1);

        // Random traffic.
        repeat (400) begin
            step(($urandom_range(0, 9) != 0), 4'($urandom), ($urandom_range(0, 9) < 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
